// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-byte dispenser.
// Generator constants, sequencer states and the LFSR step function.
package lfsr_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_RESET = 8'hFF;

    // WARMUP discards generator output, READY hands out bytes
    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_READY  = 1'b1
    } state_e;

    // One step of x^8+x^6+x^5+x^4+1, shifting toward the MSB
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // The all-zero state would lock the generator, so zero becomes one
    function automatic logic [LFSR_W-1:0] seed_guard(
        input logic [LFSR_W-1:0] seed
    );
        return (seed == '0) ? LFSR_W'(1) : seed;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW:0] idx;

    // Scan offsets from farthest to nearest so the nearest one wins
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/lfsr_rr_dispenser.sv
// Shares one 8-bit LFSR among NUM_REQ requesters: seed load, warm-up
// discard, and at least STRIDE generator steps between grants.
module lfsr_rr_dispenser
    import lfsr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int STRIDE  = 8,
    parameter int WARMUP  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_we,
    input  logic [7:0]         seed,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         rnd,
    output logic               busy,
    output logic [7:0]         lfsr_state
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [7:0] WARM_INIT  = 8'(WARMUP);
    localparam logic [7:0] STRIDE_RLD = 8'(STRIDE - 1);
    localparam state_e     ST_INIT    = (WARMUP == 0) ? ST_READY : ST_WARMUP;
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

    state_e state_q, state_d;
    logic [7:0]         s_q, s_d;
    logic [7:0]         warm_q, warm_d;
    logic [7:0]         stride_q, stride_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]         rnd_q, rnd_d;

    logic          arb_valid;
    logic [PW-1:0] arb_winner;
    logic          grant_en;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .valid (arb_valid),
        .winner(arb_winner)
    );

    assign grant_en = (state_q == ST_READY) && (stride_q == 8'd0)
                   && arb_valid && !seed_we;

    // State register plus generator, counter and output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            s_q      <= LFSR_RESET;
            warm_q   <= WARM_INIT;
            stride_q <= 8'd0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            rnd_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            warm_q   <= warm_d;
            stride_q <= stride_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rnd_q    <= rnd_d;
        end
    end

    // Next state: a seed load restarts warm-up, warm-up ends on count 1
    always_comb begin
        state_d = state_q;
        if (seed_we) begin
            state_d = ST_INIT;
        end else if (state_q == ST_WARMUP && warm_q == 8'd1) begin
            state_d = ST_READY;
        end
    end

    // Generator step, counters and the grant/byte hand-out
    always_comb begin
        s_d      = lfsr_next(s_q);
        warm_d   = warm_q;
        stride_d = stride_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        rnd_d    = rnd_q;
        if (seed_we) begin
            s_d      = seed_guard(seed);
            warm_d   = WARM_INIT;
            stride_d = 8'd0;
        end else begin
            if (state_q == ST_WARMUP) begin
                warm_d = warm_q - 8'd1;
            end
            if (grant_en) begin
                gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_winner;
                rnd_d    = s_q;
                stride_d = STRIDE_RLD;
                ptr_d    = (arb_winner == PTR_LAST) ? '0 : arb_winner + PW'(1);
            end else if (stride_q != 8'd0) begin
                stride_d = stride_q - 8'd1;
            end
        end
    end

    assign gnt        = gnt_q;
    assign rnd        = rnd_q;
    assign busy       = (state_q == ST_WARMUP);
    assign lfsr_state = s_q;

endmodule
